bht_port_scheduler: RTL and testbench
=====================================

Name: bht_port_scheduler

Overview:
- Sequences a single-ported branch history table (M saturating N-bit counters) between two requesters: fetch-side prediction lookups and resolve-side counter updates.
- Owns reset-time table initialisation, a small update FIFO, read-modify-write of counters and starvation-bounded arbitration.
- Sits between the fetch/resolve logic and the BHT counter storage.

Parameters:
- M, 64, number of table entries (power of two).
- N, 2, counter width in bits.
- PC_W, 9, PC width.
- IDX_W, log2(M), table index width; index = pc[IDX_W-1:0].
- FIFO_DEPTH, 4, update queue entries (power of two).
- STARVE_LIMIT, 8, maximum lookup grants allowed while an update waits.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- lk_valid  in  1  lookup request.
- lk_pc  in  PC_W  lookup PC.
- lk_ready  out  1  lookup granted this cycle (combinational).
- pred_valid  out  1  prediction valid.
- pred_pc  out  PC_W  PC the prediction belongs to.
- pred_taken  out  1  predicted direction.
- up_valid  in  1  update push.
- up_pc  in  PC_W  resolved branch PC.
- up_taken  in  1  resolved outcome.
- up_ready  out  1  FIFO can accept.
- mem_en  out  1  table access strobe.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  IDX_W  table index.
- mem_wdata  out  N  counter write value.
- mem_rdata  in  N  read data, valid the cycle after a read access.
- init_done  out  1  table initialised.
- fifo_count  out  log2(FIFO_DEPTH)+1  queued updates.

Behaviour:
- Reset (reset=0, async):
  - State goes to INIT; FIFO empty; starvation counter 0; init index 0.
  - All outputs 0, except up_ready=1.
  - Asserting reset mid-operation immediately drops mem_en/mem_we and discards queued updates. Initialisation restarts on release.
- INIT:
  - One write per cycle: mem_en=1, mem_we=1, mem_addr=index 0..M-1, mem_wdata=2^(N-1)-1 (weakly not-taken; 1 for N=2).
  - After index M-1: init_done=1 (sticky until reset), go to ARB.
  - Exactly M cycles. lk_ready=0 throughout; FIFO still accepts pushes.
- ARB, grant priority evaluated each cycle:
  - (a) update, if FIFO full or starve counter = STARVE_LIMIT;
  - (b) lookup, if lk_valid;
  - (c) update, if FIFO non-empty;
  - (d) idle.
- Lookup grant:
  - lk_ready=1, mem_en=1, mem_we=0, mem_addr=lk_pc index. State stays ARB, so back-to-back lookups are allowed.
  - Next cycle: pred_valid=1, pred_pc=registered lk_pc, pred_taken=mem_rdata[N-1].
  - pred_valid is a 1-cycle pulse per grant; no backpressure on predictions.
- Update grant:
  - mem_en=1, mem_we=0, mem_addr=FIFO head index; go to UPD_WR. lk_ready=0.
- UPD_WR:
  - mem_en=1, mem_we=1, same address.
  - mem_wdata = mem_rdata+1 if head.taken and mem_rdata≠2^N-1; mem_rdata-1 if !head.taken and mem_rdata≠0; else mem_rdata. Counters saturate and never wrap.
  - Pop head this cycle; return to ARB. lk_ready=0.
  - An update therefore holds the port 2 cycles. A lookup granted the cycle after UPD_WR reads the new value.
- Starvation counter:
  - +1 on each lookup grant while FIFO non-empty; saturates at STARVE_LIMIT.
  - Cleared on update grant or when FIFO empty.
- FIFO:
  - Push when up_valid && up_ready; up_ready = fifo_count<FIFO_DEPTH.
  - Push and pop in the same cycle are allowed (count unchanged). No pass-through when full.
  - Pointers wrap modulo FIFO_DEPTH.
- Aliasing: PCs with equal low IDX_W bits share an entry. No tag check. No forwarding from queued updates to lookups.

Test Plan:
- Init: release reset at t0 → mem_we=1 for exactly 64 cycles, addr 0..63, wdata=1; init_done rises on cycle 64; lookup pc=0x1A3 → pred_taken=0 one cycle after lk_ready.
- Update/alias: push (0x005,1), (0x045,1); drain → mem_wdata 2 then 3 at addr 5; lookup 0x105 → pred_taken=1, pred_pc=0x105.
- Saturation: push (0x010,0) four times from init → mem_wdata 0,0,0,0; then push (0x010,1) → wdata 1.
- Starvation: lk_valid held high, one update pushed → exactly 8 lookup grants, then lk_ready=0 for 2 cycles (read, write), then lookups resume.
- Full FIFO: push 4 updates in 4 consecutive cycles while lookups stream → up_ready=0 at fifo_count=4; update granted the next ARB cycle despite lk_valid=1; up_ready=1 after the UPD_WR pop.
- Reset mid-UPD_WR: drop reset during write cycle → mem_en/mem_we=0 immediately, fifo_count=0, init_done=0; after release, INIT restarts at addr 0.

Source files
------------

// File: rtl/bht_port_scheduler.sv
// Port scheduler for a single-ported branch history table.
// Arbitrates fetch-side lookups against resolve-side counter updates,
// initialises the table after reset, buffers updates in a small FIFO and
// performs the read-modify-write of each saturating counter.
module bht_port_scheduler #(
   parameter int M            = 64,
   parameter int N            = 2,
   parameter int PC_W         = 9,
   parameter int IDX_W        = $clog2(M),
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          lk_valid,
   input  logic [PC_W-1:0]               lk_pc,
   output logic                          lk_ready,
   output logic                          pred_valid,
   output logic [PC_W-1:0]               pred_pc,
   output logic                          pred_taken,
   input  logic                          up_valid,
   input  logic [PC_W-1:0]               up_pc,
   input  logic                          up_taken,
   output logic                          up_ready,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [IDX_W-1:0]              mem_addr,
   output logic [N-1:0]                  mem_wdata,
   input  logic [N-1:0]                  mem_rdata,
   output logic                          init_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [N-1:0] CTR_MAX  = {N{1'b1}};
   localparam logic [N-1:0] CTR_INIT = N'((1 << (N - 1)) - 1);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_ARB    = 2'd1,
      ST_UPD_WR = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic [IDX_W-1:0]   r_initIdx;
   logic               r_initDone;
   logic [IDX_W-1:0]   r_fifoIdx   [FIFO_DEPTH];
   logic               r_fifoTaken [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wrPtr;
   logic [PTR_W-1:0]   r_rdPtr;
   logic [CNT_W-1:0]   r_count;
   logic [STV_W-1:0]   r_starve;
   logic               r_predValid;
   logic [PC_W-1:0]    r_predPc;

   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_grantLk;
   logic               w_grantUp;
   logic [IDX_W-1:0]   w_headIdx;
   logic               w_headTaken;
   logic [N-1:0]       w_newCtr;
   logic               w_unusedUpPcHi;

   // Upper PC bits of an update alias onto the same entry, so only the index is queued.
   assign w_unusedUpPcHi = ^up_pc[PC_W-1:IDX_W];

   assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty     = (r_count == '0);
   assign up_ready    = (r_count < CNT_W'(FIFO_DEPTH));
   assign w_push      = up_valid && up_ready;
   assign w_headIdx   = r_fifoIdx[r_rdPtr];
   assign w_headTaken = r_fifoTaken[r_rdPtr];

   assign lk_ready    = w_grantLk;
   assign pred_valid  = r_predValid;
   assign pred_pc     = r_predPc;
   assign pred_taken  = r_predValid & mem_rdata[N-1];
   assign init_done   = r_initDone;
   assign fifo_count  = r_count;

   // Saturating increment/decrement of the counter just read for the queue head.
   always_comb begin
      w_newCtr = mem_rdata;
      if (w_headTaken && (mem_rdata != CTR_MAX)) begin
         w_newCtr = mem_rdata + N'(1);
      end else if (!w_headTaken && (mem_rdata != '0)) begin
         w_newCtr = mem_rdata - N'(1);
      end
   end

   // Next-state, grant selection and table port drive; the port is forced idle while reset is held.
   always_comb begin
      w_nextState = r_state;
      w_grantLk   = 1'b0;
      w_grantUp   = 1'b0;
      w_pop       = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      case (r_state)
         ST_INIT: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_initIdx;
            mem_wdata = CTR_INIT;
            if (r_initIdx == IDX_W'(M - 1)) begin
               w_nextState = ST_ARB;
            end
         end
         ST_ARB: begin
            if (!w_empty && (w_full || (r_starve == STV_W'(STARVE_LIMIT)))) begin
               w_grantUp = 1'b1;
            end else if (lk_valid) begin
               w_grantLk = 1'b1;
            end else if (!w_empty) begin
               w_grantUp = 1'b1;
            end
            if (w_grantLk) begin
               mem_en   = 1'b1;
               mem_addr = lk_pc[IDX_W-1:0];
            end else if (w_grantUp) begin
               mem_en      = 1'b1;
               mem_addr    = w_headIdx;
               w_nextState = ST_UPD_WR;
            end
         end
         ST_UPD_WR: begin
            mem_en      = 1'b1;
            mem_we      = 1'b1;
            mem_addr    = w_headIdx;
            mem_wdata   = w_newCtr;
            w_pop       = 1'b1;
            w_nextState = ST_ARB;
         end
         default: begin
            w_nextState = ST_INIT;
         end
      endcase
      if (!reset) begin
         w_grantLk = 1'b0;
         w_grantUp = 1'b0;
         w_pop     = 1'b0;
         mem_en    = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Initialisation sweep index and the sticky done flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_initIdx  <= '0;
         r_initDone <= 1'b0;
      end else if (r_state == ST_INIT) begin
         r_initIdx <= r_initIdx + IDX_W'(1);
         if (r_initIdx == IDX_W'(M - 1)) begin
            r_initDone <= 1'b1;
         end
      end
   end

   // Update queue payload; contents need no reset since the count gates every use.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifoIdx[r_wrPtr]   <= up_pc[IDX_W-1:0];
         r_fifoTaken[r_wrPtr] <= up_taken;
      end
   end

   // Update queue pointers and occupancy; a push and a pop together leave the count unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Counts lookups that overtook a waiting update, so the update is forced through at the limit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_starve <= '0;
      end else if (w_grantUp || w_empty) begin
         r_starve <= '0;
      end else if (w_grantLk && (r_starve != STV_W'(STARVE_LIMIT))) begin
         r_starve <= r_starve + STV_W'(1);
      end
   end

   // Prediction pulse and PC, aligned with the read data returning one cycle after a lookup grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_predValid <= 1'b0;
         r_predPc    <= '0;
      end else begin
         r_predValid <= w_grantLk;
         if (w_grantLk) begin
            r_predPc <= lk_pc;
         end
      end
   end

endmodule

// File: tb/tb_bht_port_scheduler.sv
// Testbench for bht_port_scheduler: directed scenarios plus a randomized phase,
// all checked against a transaction-level model of table contents and the update queue.
module tb_bht_port_scheduler;

   localparam int M  = 64;
   localparam int N  = 2;
   localparam int PW = 9;
   localparam int FD = 4;
   localparam int SL = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          lk_valid;
   logic [PW-1:0] lk_pc;
   logic          lk_ready;
   logic          pred_valid;
   logic [PW-1:0] pred_pc;
   logic          pred_taken;
   logic          up_valid;
   logic [PW-1:0] up_pc;
   logic          up_taken;
   logic          up_ready;
   logic          mem_en;
   logic          mem_we;
   logic [5:0]    mem_addr;
   logic [N-1:0]  mem_wdata;
   logic [N-1:0]  mem_rdata = '0;
   logic          init_done;
   logic [2:0]    fifo_count;

   always #5 clk = ~clk;

   bht_port_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .lk_valid   (lk_valid),
      .lk_pc      (lk_pc),
      .lk_ready   (lk_ready),
      .pred_valid (pred_valid),
      .pred_pc    (pred_pc),
      .pred_taken (pred_taken),
      .up_valid   (up_valid),
      .up_pc      (up_pc),
      .up_taken   (up_taken),
      .up_ready   (up_ready),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .init_done  (init_done),
      .fifo_count (fifo_count)
   );

   // Counter storage: synchronous write, registered read data one cycle after a read.
   logic [N-1:0] memArr [M];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) memArr[mem_addr] <= mem_wdata;
         else        mem_rdata <= memArr[mem_addr];
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   int total = 0;
   int bad   = 0;

   typedef struct {int idx; int taken;} upd_t;
   int   refTable [M];
   upd_t refQ [$];
   int   initCount;
   bit   refInit;
   bit   updPhase;
   int   starveRun;
   bit   expPred;
   int   expPredPc;
   int   expPredTaken;
   int   wrLog [$];
   bit   rdyLog [$];
   bit   upLog [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int satNext(input int c, input int t);
      if (t != 0 && c != (1 << N) - 1) return c + 1;
      if (t == 0 && c != 0) return c - 1;
      return c;
   endfunction

   task automatic resetModel();
      refQ.delete();
      initCount = 0;
      refInit   = 1'b0;
      updPhase  = 1'b0;
      starveRun = 0;
      expPred   = 1'b0;
   endtask

   // Compares this cycle's outputs with the model, then advances the model by one cycle.
   task automatic checkOutput();
      bit canPush;
      bit mustUp;
      int idx;
      int nv;
      check("pred_valid", pred_valid, expPred);
      if (expPred) begin
         check("pred_pc", pred_pc, expPredPc);
         check("pred_taken", pred_taken, expPredTaken);
      end
      expPred = 1'b0;
      check("fifo_count", fifo_count, refQ.size());
      check("up_ready", up_ready, (refQ.size() < FD) ? 1 : 0);
      check("init_done", init_done, refInit);
      canPush = (refQ.size() < FD);
      rdyLog.push_back(lk_ready);
      upLog.push_back(up_ready);
      if (!refInit) begin
         check("init_lk_ready", lk_ready, 0);
         check("init_mem_en", mem_en, 1);
         check("init_mem_we", mem_we, 1);
         check("init_addr", mem_addr, initCount);
         check("init_wdata", mem_wdata, (1 << (N - 1)) - 1);
         refTable[initCount] = (1 << (N - 1)) - 1;
         initCount++;
         if (initCount == M) refInit = 1'b1;
      end else if (updPhase) begin
         idx = refQ[0].idx;
         nv  = satNext(refTable[idx], refQ[0].taken);
         check("wr_lk_ready", lk_ready, 0);
         check("wr_mem_en", mem_en, 1);
         check("wr_mem_we", mem_we, 1);
         check("wr_addr", mem_addr, idx);
         check("wr_wdata", mem_wdata, nv);
         wrLog.push_back(idx * 16 + nv);
         refTable[idx] = nv;
         void'(refQ.pop_front());
         updPhase = 1'b0;
      end else begin
         mustUp = (refQ.size() > 0) && (refQ.size() == FD || starveRun == SL);
         if (mustUp || (!lk_valid && refQ.size() > 0)) begin
            check("up_lk_ready", lk_ready, 0);
            check("up_mem_en", mem_en, 1);
            check("up_mem_we", mem_we, 0);
            check("up_addr", mem_addr, refQ[0].idx);
            updPhase  = 1'b1;
            starveRun = 0;
         end else if (lk_valid) begin
            idx = int'(lk_pc) % M;
            check("lk_lk_ready", lk_ready, 1);
            check("lk_mem_en", mem_en, 1);
            check("lk_mem_we", mem_we, 0);
            check("lk_addr", mem_addr, idx);
            expPred      = 1'b1;
            expPredPc    = int'(lk_pc);
            expPredTaken = (refTable[idx] >= (1 << (N - 1))) ? 1 : 0;
            if (refQ.size() > 0) starveRun = (starveRun + 1 > SL) ? SL : starveRun + 1;
            else                 starveRun = 0;
         end else begin
            check("idle_lk_ready", lk_ready, 0);
            check("idle_mem_en", mem_en, 0);
            starveRun = 0;
         end
      end
      if (up_valid && canPush) begin
         refQ.push_back('{idx: int'(up_pc) % M, taken: int'(up_taken)});
      end
   endtask

   // Drives one cycle of inputs at a falling edge, checks, and moves to the next falling edge.
   task automatic applyStimulus(input bit lv, input logic [PW-1:0] lp,
                                input bit uv, input logic [PW-1:0] upc, input bit ut);
      lk_valid = lv;
      lk_pc    = lp;
      up_valid = uv;
      up_pc    = upc;
      up_taken = ut;
      #1;
      checkOutput();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, '0, 0);
   endtask

   // Pulls reset mid-cycle and confirms the port and queue drop at once.
   task automatic doAsyncReset(input bit expectWrite);
      lk_valid = 1'b0;
      up_valid = 1'b0;
      #1;
      if (expectWrite) check("pre_rst_we", mem_we, 1);
      #1;
      reset = 1'b0;
      #1;
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_init_done", init_done, 0);
      check("rst_up_ready", up_ready, 1);
      check("rst_lk_ready", lk_ready, 0);
      check("rst_pred_valid", pred_valid, 0);
      resetModel();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      logic [PW-1:0] p;
      bit lv;
      int n;
      int ones;
      reset    = 1'b0;
      lk_valid = 1'b0;
      lk_pc    = '0;
      up_valid = 1'b0;
      up_pc    = '0;
      up_taken = 1'b0;
      resetModel();
      repeat (3) @(negedge clk);
      check("por_mem_en", mem_en, 0);
      check("por_up_ready", up_ready, 1);
      check("por_init_done", init_done, 0);
      reset = 1'b1;

      // Initialisation sweep, then a lookup of a freshly initialised entry.
      idle(M);
      applyStimulus(1, 9'h1A3, 0, '0, 0);
      check("init_pred_valid", pred_valid, 1);
      check("init_pred_taken", pred_taken, 0);
      check("init_pred_pc", pred_pc, 9'h1A3);
      idle(2);

      // Two aliasing updates to entry 5, then a lookup through a third alias.
      wrLog.delete();
      applyStimulus(0, '0, 1, 9'h005, 1);
      applyStimulus(0, '0, 1, 9'h045, 1);
      idle(6);
      check("alias_wr_count", wrLog.size(), 2);
      if (wrLog.size() == 2) begin
         check("alias_wr0", wrLog[0], 5 * 16 + 2);
         check("alias_wr1", wrLog[1], 5 * 16 + 3);
      end
      applyStimulus(1, 9'h105, 0, '0, 0);
      check("alias_pred_taken", pred_taken, 1);
      check("alias_pred_pc", pred_pc, 9'h105);
      idle(1);

      // Decrement saturation at zero, then one increment.
      wrLog.delete();
      for (int i = 0; i < 4; i++) applyStimulus(0, '0, 1, 9'h010, 0);
      idle(10);
      applyStimulus(0, '0, 1, 9'h010, 1);
      idle(4);
      check("sat_wr_count", wrLog.size(), 5);
      if (wrLog.size() == 5) begin
         for (int i = 0; i < 4; i++) check("sat_wr_zero", wrLog[i], 16 * 16 + 0);
         check("sat_wr_inc", wrLog[4], 16 * 16 + 1);
      end

      // Starvation bound with lookups held high.
      rdyLog.delete();
      applyStimulus(1, 9'h0AA, 1, 9'h020, 1);
      for (int i = 0; i < 14; i++) applyStimulus(1, 9'($urandom), 0, '0, 0);
      ones = 0;
      for (int i = 1; i <= 8; i++) ones += rdyLog[i];
      check("starve_grants", ones, 8);
      check("starve_rd", rdyLog[9], 0);
      check("starve_wr", rdyLog[10], 0);
      check("starve_resume", rdyLog[11], 1);
      idle(3);

      // Full queue forces an update despite streaming lookups.
      rdyLog.delete();
      upLog.delete();
      for (int i = 0; i < 4; i++) applyStimulus(1, 9'($urandom), 1, 9'($urandom), i[0]);
      for (int i = 0; i < 3; i++) applyStimulus(1, 9'($urandom), 0, '0, 0);
      check("full_lk3", rdyLog[3], 1);
      check("full_lk4", rdyLog[4], 0);
      check("full_lk5", rdyLog[5], 0);
      check("full_lk6", rdyLog[6], 1);
      check("full_up4", upLog[4], 0);
      check("full_up5", upLog[5], 0);
      check("full_up6", upLog[6], 1);
      idle(12);

      // Reset during the write half of an update.
      applyStimulus(0, '0, 1, 9'h033, 1);
      applyStimulus(0, '0, 1, 9'h034, 0);
      n = 0;
      while (!updPhase && n < 10) begin
         idle(1);
         n++;
      end
      check("reach_upd_wr", updPhase, 1);
      doAsyncReset(1);
      idle(M + 2);

      // Randomized traffic with aliasing hot spots, lookup bursts and one async reset.
      for (int c = 0; c < 900; c++) begin
         if (c == 450) doAsyncReset(0);
         p = 9'($urandom);
         if ($urandom % 3 == 0) p[5:0] = 6'($urandom % 4);
         lv = ((c / 60) % 2 == 1) ? 1'b1 : 1'($urandom % 2);
         applyStimulus(lv, p, ($urandom % 100) < 45, {3'($urandom), 6'($urandom % 4)}, 1'($urandom));
      end
      idle(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
